// File: rtl/mcycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mcycle_ctrl
// Brief    : Multicycle MIPS32 control sequencer (Fetch/Decode/Execute/Memory/
//            Writeback) with stall, optional memory handshake and an
//            illegal-opcode trap. Define CTRL_PERF_EN for cycle/retire counters.
// Revision : 1.0
// ============================================================================
module mcycle_ctrl #(
    parameter int MEM_HS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [5:0]       op,
    input  logic             stall,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             imem_rd,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_br_we,
    output logic             pc_jmp_we,
    output logic             alu_en,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             reg_we,
    output logic             retire,
`ifdef CTRL_PERF_EN
    output logic             err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`else
    output logic             err
`endif
);

    typedef enum logic [2:0] {
        S_INIT   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECD   = 3'b010,
        S_EXE    = 3'b011,
        S_OPMEM  = 3'b100,
        S_WRBACK = 3'b101,
        S_ERR    = 3'b110,
        S_BAD    = 3'b111
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    state_t r_state;
    state_t w_next;
    logic   w_adv;
    logic   w_is_br;
    logic   w_is_lw;
    logic   w_is_sw;
    logic   w_is_jmp;
    logic   w_needs_exe;

    assign w_is_br  = (op == c_OP_BEQ) || (op == c_OP_BNE);
    assign w_is_lw  = (op == c_OP_LW);
    assign w_is_sw  = (op == c_OP_SW);
    assign w_is_jmp = (op == c_OP_J) || (op == c_OP_JAL);
    assign w_needs_exe = (op == c_OP_RTYPE) || w_is_br || (op == c_OP_ADDI) ||
                         (op == c_OP_SLTI) || (op == c_OP_ANDI) || (op == c_OP_ORI) ||
                         (op == c_OP_LUI) || w_is_lw || w_is_sw;

    // Memory-facing stages additionally wait for the handshake when it is enabled.
    assign w_adv = !stall &&
                   (((r_state != S_FETCH) && (r_state != S_OPMEM)) ||
                    (MEM_HS == 0) || mem_ready);

    always_comb begin
        w_next = r_state;
        if (r_state == S_BAD) begin
            w_next = S_INIT;
        end else if (w_adv) begin
            case (r_state)
                S_INIT:   w_next = S_FETCH;
                S_FETCH:  w_next = S_DECD;
                S_DECD: begin
                    if (op == c_OP_J)        w_next = S_FETCH;
                    else if (op == c_OP_JAL) w_next = S_WRBACK;
                    else if (w_needs_exe)    w_next = S_EXE;
                    else                     w_next = S_ERR;
                end
                S_EXE: begin
                    if (w_is_br)                 w_next = S_FETCH;
                    else if (w_is_lw || w_is_sw) w_next = S_OPMEM;
                    else                         w_next = S_WRBACK;
                end
                S_OPMEM:  w_next = w_is_lw ? S_WRBACK : S_FETCH;
                S_WRBACK: w_next = S_FETCH;
                S_ERR:    w_next = S_ERR;
                default:  w_next = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        imem_rd   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_br_we  = 1'b0;
        pc_jmp_we = 1'b0;
        alu_en    = 1'b0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        reg_we    = 1'b0;
        if (!clr && !stall) begin
            case (r_state)
                S_FETCH: begin
                    imem_rd = 1'b1;
                    ir_we   = w_adv;
                    pc_we   = w_adv;
                end
                S_DECD:   pc_jmp_we = w_is_jmp;
                S_EXE: begin
                    alu_en   = 1'b1;
                    pc_br_we = w_is_br;
                end
                S_OPMEM: begin
                    dmem_rd = w_is_lw;
                    dmem_wr = w_is_sw;
                end
                S_WRBACK: reg_we = 1'b1;
                default:  ;
            endcase
        end
    end

    // Leaving Init for the first Fetch is not the end of an instruction.
    assign retire = !clr && w_adv && (r_state != S_INIT) && (r_state != S_BAD) &&
                    (w_next == S_FETCH);
    assign err    = !clr && (r_state == S_ERR);
    assign state  = r_state;

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            if (retire) r_ret_cnt <= r_ret_cnt + CNT_W'(1);
        end
    end

    assign cyc_cnt = r_cyc_cnt;
    assign ret_cnt = r_ret_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcycle_ctrl
// Brief    : Scoreboard bench for mcycle_ctrl; one DUT without and one with the
//            memory handshake. Counter scenario active when CTRL_PERF_EN is set.
// Revision : 1.0
// ============================================================================
module tb_mcycle_ctrl;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_JAL  = 6'b000011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_BNE  = 6'b000101;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BAD  = 6'b111111;

    localparam logic [2:0] c_ST_INIT = 3'd0, c_ST_FETCH = 3'd1, c_ST_DECD = 3'd2,
                           c_ST_EXE  = 3'd3, c_ST_OPMEM = 3'd4, c_ST_WRBACK = 3'd5,
                           c_ST_ERR  = 3'd6;

    // Output bit map: imem_rd ir_we pc_we pc_br_we pc_jmp_we alu_en dmem_rd dmem_wr reg_we retire err
    localparam logic [10:0] c_IMEM = 11'h400, c_IRW = 11'h200, c_PCW = 11'h100,
                            c_BR   = 11'h080, c_JMP = 11'h040, c_ALU = 11'h020,
                            c_DRD  = 11'h010, c_DWR = 11'h008, c_REG = 11'h004,
                            c_RET  = 11'h002, c_ERR = 11'h001;
    localparam logic [10:0] c_F = c_IMEM | c_IRW | c_PCW;

    typedef struct packed {
        logic [5:0]  op;
        logic        stall;
        logic        mr;
        logic [13:0] exp;
    } step_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       stall;
    logic       mem_ready;
    logic [5:0] op;
    wire  [2:0] st0, st1;
    wire  [10:0] s0, s1;
    wire  [13:0] obs0 = {st0, s0};
    wire  [13:0] obs1 = {st1, s1};
`ifdef CTRL_PERF_EN
    wire  [3:0] cyc0, ret0, cyc1, ret1;
`endif

    logic [13:0] sb[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mcycle_ctrl #(.MEM_HS(0), .CNT_W(4)) dut0 (
        .clk(clk), .clr(clr), .op(op), .stall(stall), .mem_ready(mem_ready),
        .state(st0), .imem_rd(s0[10]), .ir_we(s0[9]), .pc_we(s0[8]),
        .pc_br_we(s0[7]), .pc_jmp_we(s0[6]), .alu_en(s0[5]), .dmem_rd(s0[4]),
        .dmem_wr(s0[3]), .reg_we(s0[2]), .retire(s0[1]),
`ifdef CTRL_PERF_EN
        .err(s0[0]), .cyc_cnt(cyc0), .ret_cnt(ret0)
`else
        .err(s0[0])
`endif
    );

    mcycle_ctrl #(.MEM_HS(1), .CNT_W(4)) dut1 (
        .clk(clk), .clr(clr), .op(op), .stall(stall), .mem_ready(mem_ready),
        .state(st1), .imem_rd(s1[10]), .ir_we(s1[9]), .pc_we(s1[8]),
        .pc_br_we(s1[7]), .pc_jmp_we(s1[6]), .alu_en(s1[5]), .dmem_rd(s1[4]),
        .dmem_wr(s1[3]), .reg_we(s1[2]), .retire(s1[1]),
`ifdef CTRL_PERF_EN
        .err(s1[0]), .cyc_cnt(cyc1), .ret_cnt(ret1)
`else
        .err(s1[0])
`endif
    );

    function automatic step_t mk(logic [5:0] o, logic s, logic m, logic [2:0] st, logic [10:0] v);
        return '{op: o, stall: s, mr: m, exp: {st, v}};
    endfunction

    task automatic do_reset();
        clr = 1'b1; stall = 1'b0; mem_ready = 1'b0; op = c_OP_R;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        clr = 1'b1; stall = 1'b1; mem_ready = 1'b1; op = c_OP_BAD;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(14'd0);
        @(negedge clk);
        e = sb.pop_front();
        n_checks += 2;
        if (obs0 !== e) begin n_errors++; $display("FAIL reset_dut0: got %b expected %b", obs0, e); end
        if (obs1 !== e) begin n_errors++; $display("FAIL reset_dut1: got %b expected %b", obs1, e); end
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({c_ST_INIT, 11'd0});
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin n_errors++; $display("FAIL init_stall[%0d]: got %b expected %b", i, obs0, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        step_t t[$];
        logic [13:0] e;
        do_reset();
        t.push_back(mk(c_OP_R, 0, 0, c_ST_INIT,   11'd0));
        t.push_back(mk(c_OP_R, 0, 0, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_R, 0, 0, c_ST_DECD,   11'd0));
        t.push_back(mk(c_OP_R, 0, 0, c_ST_EXE,    c_ALU));
        t.push_back(mk(c_OP_R, 0, 0, c_ST_WRBACK, c_REG | c_RET));
        t.push_back(mk(c_OP_R, 0, 0, c_ST_FETCH,  c_F));
        foreach (t[i]) begin
            op = t[i].op; stall = t[i].stall; mem_ready = t[i].mr;
            sb.push_back(t[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin n_errors++; $display("FAIL rtype[%0d]: got %b expected %b", i, obs0, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_handshake();
        step_t t[$];
        logic [13:0] e;
        do_reset();
        t.push_back(mk(c_OP_LW, 0, 0, c_ST_INIT,  11'd0));
        t.push_back(mk(c_OP_LW, 0, 1, c_ST_FETCH, c_F));
        t.push_back(mk(c_OP_LW, 0, 0, c_ST_DECD,  11'd0));
        t.push_back(mk(c_OP_LW, 0, 0, c_ST_EXE,   c_ALU));
        for (int k = 0; k < 3; k++) t.push_back(mk(c_OP_LW, 0, 0, c_ST_OPMEM, c_DRD));
        t.push_back(mk(c_OP_LW, 1, 1, c_ST_OPMEM,  11'd0));
        t.push_back(mk(c_OP_LW, 0, 1, c_ST_OPMEM,  c_DRD));
        t.push_back(mk(c_OP_LW, 0, 0, c_ST_WRBACK, c_REG | c_RET));
        t.push_back(mk(c_OP_R,  0, 0, c_ST_FETCH,  c_IMEM));
        t.push_back(mk(c_OP_R,  0, 1, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_R,  0, 0, c_ST_DECD,   11'd0));
        foreach (t[i]) begin
            op = t[i].op; stall = t[i].stall; mem_ready = t[i].mr;
            sb.push_back(t[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs1 !== e) begin n_errors++; $display("FAIL lw_hs[%0d]: got %b expected %b", i, obs1, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t t[$];
        logic [13:0] e;
        do_reset();
        t.push_back(mk(c_OP_SW,  0, 0, c_ST_INIT,   11'd0));
        t.push_back(mk(c_OP_SW,  0, 0, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_SW,  0, 0, c_ST_DECD,   11'd0));
        t.push_back(mk(c_OP_SW,  0, 0, c_ST_EXE,    c_ALU));
        t.push_back(mk(c_OP_SW,  0, 0, c_ST_OPMEM,  c_DWR | c_RET));
        t.push_back(mk(c_OP_BEQ, 0, 0, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_BEQ, 0, 0, c_ST_DECD,   11'd0));
        t.push_back(mk(c_OP_BEQ, 0, 0, c_ST_EXE,    c_ALU | c_BR | c_RET));
        t.push_back(mk(c_OP_J,   0, 0, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_J,   0, 0, c_ST_DECD,   c_JMP | c_RET));
        t.push_back(mk(c_OP_JAL, 0, 0, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_JAL, 0, 0, c_ST_DECD,   c_JMP));
        t.push_back(mk(c_OP_JAL, 0, 0, c_ST_WRBACK, c_REG | c_RET));
        t.push_back(mk(c_OP_BNE, 0, 0, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_BNE, 0, 0, c_ST_DECD,   11'd0));
        t.push_back(mk(c_OP_BNE, 0, 0, c_ST_EXE,    c_ALU | c_BR | c_RET));
        t.push_back(mk(c_OP_R,   0, 0, c_ST_FETCH,  c_F));
        foreach (t[i]) begin
            op = t[i].op; stall = t[i].stall; mem_ready = t[i].mr;
            sb.push_back(t[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin n_errors++; $display("FAIL b2b[%0d]: got %b expected %b", i, obs0, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        step_t t[$];
        logic [13:0] e;
        do_reset();
        t.push_back(mk(c_OP_ADDI, 1, 0, c_ST_INIT,   11'd0));
        t.push_back(mk(c_OP_ADDI, 0, 0, c_ST_INIT,   11'd0));
        t.push_back(mk(c_OP_ADDI, 1, 1, c_ST_FETCH,  11'd0));
        t.push_back(mk(c_OP_ADDI, 0, 1, c_ST_FETCH,  c_F));
        t.push_back(mk(c_OP_ADDI, 0, 0, c_ST_DECD,   11'd0));
        t.push_back(mk(c_OP_ADDI, 1, 0, c_ST_EXE,    11'd0));
        t.push_back(mk(c_OP_ADDI, 1, 0, c_ST_EXE,    11'd0));
        t.push_back(mk(c_OP_ADDI, 0, 0, c_ST_EXE,    c_ALU));
        t.push_back(mk(c_OP_ADDI, 0, 0, c_ST_WRBACK, c_REG | c_RET));
        t.push_back(mk(c_OP_ADDI, 0, 1, c_ST_FETCH,  c_F));
        foreach (t[i]) begin
            op = t[i].op; stall = t[i].stall; mem_ready = t[i].mr;
            sb.push_back(t[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs1 !== e) begin n_errors++; $display("FAIL stall[%0d]: got %b expected %b", i, obs1, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_err();
        step_t t[$];
        logic [13:0] e;
        do_reset();
        t.push_back(mk(c_OP_BAD, 0, 0, c_ST_INIT,  11'd0));
        t.push_back(mk(c_OP_BAD, 0, 0, c_ST_FETCH, c_F));
        t.push_back(mk(c_OP_BAD, 0, 0, c_ST_DECD,  11'd0));
        for (int k = 0; k < 10; k++)
            t.push_back(mk(k[0] ? c_OP_J : c_OP_R, 0, 0, c_ST_ERR, c_ERR));
        foreach (t[i]) begin
            op = t[i].op; stall = t[i].stall; mem_ready = t[i].mr;
            sb.push_back(t[i].exp);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs0 !== e) begin n_errors++; $display("FAIL err[%0d]: got %b expected %b", i, obs0, e); end
            @(posedge clk); #1;
        end
        clr = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        sb.push_back({c_ST_INIT, 11'd0});
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (obs0 !== e) begin n_errors++; $display("FAIL err_clr: got %b expected %b", obs0, e); end
        @(posedge clk); #1;
        stall = 1'b0;
    endtask

`ifdef CTRL_PERF_EN
    task automatic test_perf();
        logic [13:0] e;
        do_reset();
        op = c_OP_J;
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            // One retire per completed Fetch/Decd pair after the Init->Fetch edge.
            sb.push_back({6'd0, 4'(k), (k > 0) ? 4'((k - 1) / 2) : 4'd0});
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({cyc0, ret0} !== e[7:0]) begin
                n_errors++;
                $display("FAIL perf[%0d]: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                         k, cyc0, ret0, e[7:4], e[3:0]);
            end
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; stall = 1'b0; mem_ready = 1'b0; op = c_OP_R;
        test_reset();
        test_rtype();
        test_lw_handshake();
        test_back_to_back();
        test_stall();
        test_err();
`ifdef CTRL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Parametrised multicycle control sequencer for the MIPS32 core; next generation of the fixed six-state control FSM. Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback, skipping stages an opcode does not need. Supports a global stall, an optional memory-ready handshake and an illegal-opcode trap state. Emits per-stage write/enable strobes to the datapath.

## Interface
- `MEM_HS`, 1: 1 = Fetch and OpMem wait for `mem_ready`; 0 = both are single-cycle.
- `CNT_W`, 32: width of performance counters; used only with `CTRL_PERF_EN`.
- `clk`  in  1  clock; all state changes on rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `op`  in  6  opcode from IR (`ir[31:26]`); sampled in Decd, Exe and OpMem only.
- `stall`  in  1  freeze: hold state, deassert all strobes.
- `mem_ready`  in  1  memory access complete; ignored when `MEM_HS`=0.
- `state`  out  3  current state.
- `imem_rd`  out  1  instruction read request.
- `ir_we`  out  1  IR load.
- `pc_we`  out  1  PC <= PC+4.
- `pc_br_we`  out  1  conditional PC load (beq/bne); datapath applies the condition.
- `pc_jmp_we`  out  1  jump PC load (j/jal).
- `alu_en`  out  1  ALU result register load.
- `dmem_rd`  out  1  data read request.
- `dmem_wr`  out  1  data write request.
- `reg_we`  out  1  register file write.
- `retire`  out  1  one-cycle pulse on an instruction's final cycle.
- `err`  out  1  high while in Err.

## Operation
- States: Init=000, Fetch=001, Decd=010, Exe=011, OpMem=100, WrBack=101, Err=110. Encoding 111 is unreachable and goes to Init.
- Advance condition `adv`: `!stall`, and in Fetch/OpMem also `mem_ready` when `MEM_HS`=1.
- Init -> Fetch unconditionally, unless `stall`.
- Fetch -> Decd.
- Decd is resolved by `op`:
  - j (000010): -> Fetch.
  - jal (000011): -> WrBack.
  - R-type 000000, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011: -> Exe.
  - Any other opcode: -> Err.
- Exe: beq/bne -> Fetch; lw/sw -> OpMem; all others -> WrBack.
- OpMem: lw -> WrBack; sw -> Fetch.
- WrBack -> Fetch.
- Err is terminal; only `clr` leaves it.
- Strobes are Moore decodes of `state`/`op`, all forced to 0 when `stall`=1:
  - Fetch: `imem_rd`=1. `ir_we`=`pc_we`=`adv`.
  - Decd: `pc_jmp_we`=1 for j/jal.
  - Exe: `alu_en`=1; `pc_br_we`=1 for beq/bne.
  - OpMem: `dmem_rd`=1 for lw, `dmem_wr`=1 for sw. Both held until `adv`.
  - WrBack: `reg_we`=1.
- `retire`=1 when `adv` and the next state is Fetch, excluding Init -> Fetch.
- `err` = (state==Err).

## Timing
- On `clr`: `state`=Init on the next edge. While in reset and Init, all strobes, `retire` and `err` are 0. `clr` takes priority over `stall` in any state, including mid-OpMem and Err.
- Instruction latency with `MEM_HS`=0, no stall, counted in cycles from Fetch: j=2, beq/bne=3, jal=3, R/I-ALU=4, sw=4, lw=5.
- With `MEM_HS`=1, each Fetch/OpMem cycle with `mem_ready`=0 adds one cycle; strobes are held steady during the wait.
- `stall` and `mem_ready` in the same cycle: the stall wins and `mem_ready` is ignored. The memory must re-assert `mem_ready` after the stall.
- `stall` costs exactly one cycle per stalled cycle, in any state.

## Configuration
- `CTRL_PERF_EN` defined: adds outputs `cyc_cnt[CNT_W-1:0]` and `ret_cnt[CNT_W-1:0]`.
  - `cyc_cnt` increments every cycle with `clr`=0, including stalled cycles and cycles in Err.
  - `ret_cnt` increments on `retire`.
  - Both clear to 0 on `clr` and wrap modulo 2^CNT_W.
- Not defined: the ports and the counters do not exist; all other behaviour is identical.

## Test plan
- `MEM_HS`=0, op=000000 after `clr`: state sequence 000,001,010,011,101,001. `reg_we` is 1 only in the WrBack cycle; `retire` is 1 in the WrBack cycle.
- `MEM_HS`=1, lw, `mem_ready` low for 3 cycles in OpMem: `dmem_rd` is held for 4 cycles, then WrBack; lw latency = 8 with a 1-cycle fetch.
- Sequences for sw, beq, j and jal: lengths 4/3/2/3.
  - `dmem_wr` is pulsed only for sw.
  - `pc_br_we` is 1 only in the beq Exe cycle.
  - `pc_jmp_we` is 1 in the j/jal Decd cycle.
- `stall` high for 2 cycles in Exe, with `mem_ready` high during the stall in Fetch: state is held and all strobes are 0; latency grows by 2.
- op=111111: Decd -> Err, `err`=1 and held across 10 cycles. Asserting `clr` returns the FSM to Init with `err`=0.
- `CTRL_PERF_EN`, `CNT_W`=4, `MEM_HS`=0, back-to-back j: `ret_cnt` wraps 15 -> 0 after 16 retires; `cyc_cnt` = 33 mod 16 = 1 after 33 cycles.
